sync_lane_arbiter: RTL and testbench



---
 rtl/sync_lane_pkg.sv | 19 +
 rtl/sync_lane_arbiter_rr_arbiter.sv | 36 +++
 rtl/sync_lane_arbiter.sv | 161 ++++++++++++++++
 tb/tb_sync_lane_arbiter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/sync_lane_pkg.sv
// Shared types and constants for the synchronizer lane arbiter.
package sync_lane_pkg;

  localparam int MAX_NREQ = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_GAP    = 3'd4
  } state_e;

  // Cycles from the first START cycle through the ack cycle, inclusive.
  function automatic int frame_cycles(input int w, input int hold, input int gap, input bit parity);
    return (w + 1 + (parity ? 1 : 0)) * hold + gap;
  endfunction

endpackage

// File: rtl/sync_lane_arbiter_rr_arbiter.sv
// Round-robin picker: first requester at or after ptr_i, as one-hot and index.
module rr_arbiter
  import sync_lane_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [2:0]      ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [2:0]      idx_o,
  output logic            any_o
);

  logic [NREQ-1:0] rot;
  logic [2:0]      pos;
  logic [3:0]      sum;

  // Rotate so ptr_i lands at bit 0; lowest set bit is then the winner.
  always_comb begin
    rot   = NREQ'({req_i, req_i} >> ptr_i);
    pos   = '0;
    any_o = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        pos   = 3'(k);
        any_o = 1'b1;
      end
    end
    sum = {1'b0, ptr_i} + {1'b0, pos};
    if (sum >= 4'(NREQ)) sum = sum - 4'(NREQ);
    idx_o = sum[2:0];
    gnt_o = '0;
    for (int i = 0; i < NREQ; i++) gnt_o[i] = any_o && (idx_o == 3'(i));
  end

endmodule

// File: rtl/sync_lane_arbiter.sv
// Round-robin serializer of requester words onto a shared 1-bit sync lane.
// Optional even-parity bit after the data bits: define SYNC_LANE_PARITY_EN.
module sync_lane_arbiter
  import sync_lane_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int HOLD = 4,
  parameter int GAP  = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] data,
  output logic [NREQ-1:0]   ack,
  output logic              busy,
  output logic [2:0]        grant_id,
  output logic              lane_en,
  output logic              lane_d
);

  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int BW = (W > 1) ? $clog2(W) : 1;
  localparam logic [HW-1:0] HOLD_LD  = HW'(HOLD - 1);
  localparam logic [GW-1:0] GAP_LD   = GW'(GAP - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(W - 1);

  state_e          state_q;
  logic [W-1:0]    sh_q;
  logic [HW-1:0]   hold_q;
  logic [BW-1:0]   bit_q;
  logic [GW-1:0]   gap_q;
  logic [2:0]      ptr_q;
  logic [2:0]      grant_q;
  logic [NREQ-1:0] gnt_q;
  logic [NREQ-1:0] ack_q;
  logic            lane_q;
`ifdef SYNC_LANE_PARITY_EN
  logic            par_q;
`endif

  logic [NREQ-1:0] arb_gnt;
  logic [2:0]      arb_idx;
  logic            arb_any;
  logic [W-1:0]    win_word;
  logic [W-1:0]    sh_nx;
  logic [2:0]      ptr_d;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  always_comb begin
    win_word = '0;
    for (int i = 0; i < NREQ; i++)
      if (arb_gnt[i]) win_word = win_word | data[i*W +: W];
    ptr_d = (arb_idx == 3'(NREQ - 1)) ? 3'd0 : arb_idx + 3'd1;
    sh_nx = sh_q >> 1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      sh_q    <= '0;
      hold_q  <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
      ptr_q   <= '0;
      grant_q <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
      lane_q  <= 1'b0;
`ifdef SYNC_LANE_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      ack_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (arb_any) begin
            state_q <= ST_START;
            sh_q    <= win_word;
            grant_q <= arb_idx;
            gnt_q   <= arb_gnt;
            ptr_q   <= ptr_d;
            lane_q  <= 1'b1;
            hold_q  <= HOLD_LD;
`ifdef SYNC_LANE_PARITY_EN
            par_q   <= ^win_word;
`endif
          end
        end
        ST_START: begin
          if (hold_q == '0) begin
            state_q <= ST_DATA;
            lane_q  <= sh_q[0];
            hold_q  <= HOLD_LD;
            bit_q   <= '0;
          end else begin
            hold_q <= hold_q - 1'b1;
          end
        end
        ST_DATA: begin
          if (hold_q != '0) begin
            hold_q <= hold_q - 1'b1;
          end else if (bit_q == BIT_LAST) begin
`ifdef SYNC_LANE_PARITY_EN
            state_q <= ST_PARITY;
            lane_q  <= par_q;
            hold_q  <= HOLD_LD;
`else
            state_q <= ST_GAP;
            lane_q  <= 1'b0;
            gap_q   <= GAP_LD;
            ack_q   <= (GAP == 1) ? gnt_q : '0;
`endif
          end else begin
            sh_q   <= sh_nx;
            lane_q <= sh_nx[0];
            bit_q  <= bit_q + 1'b1;
            hold_q <= HOLD_LD;
          end
        end
`ifdef SYNC_LANE_PARITY_EN
        ST_PARITY: begin
          if (hold_q == '0) begin
            state_q <= ST_GAP;
            lane_q  <= 1'b0;
            gap_q   <= GAP_LD;
            ack_q   <= (GAP == 1) ? gnt_q : '0;
          end else begin
            hold_q <= hold_q - 1'b1;
          end
        end
`endif
        ST_GAP: begin
          // ack is registered, so it is armed one cycle ahead of the last gap cycle.
          if (gap_q == '0) begin
            state_q <= ST_IDLE;
          end else begin
            gap_q <= gap_q - 1'b1;
            if (gap_q == GW'(1)) ack_q <= gnt_q;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ack      = ack_q;
  assign busy     = (state_q != ST_IDLE);
  assign grant_id = grant_q;
  assign lane_en  = 1'b1;
  assign lane_d   = lane_q;

endmodule

// File: tb/tb_sync_lane_arbiter.sv
// Self-checking bench: frame-level reference model of lane waveform, ack timing and round-robin order.
module tb_sync_lane_arbiter;
  localparam int NR = 4, WD = 8, HD = 4, GP = 4;
`ifdef SYNC_LANE_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FL = (1 + WD + PB) * HD + GP;

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic [NR-1:0]   req = '0;
  logic [NR*WD-1:0] data = '0;
  logic [NR-1:0]   ack;
  logic            busy;
  logic [2:0]      grant_id;
  logic            lane_en, lane_d;

  int checks = 0, passed = 0;
  int last = NR - 1;

  always #5 CLK = ~CLK;

  sync_lane_arbiter #(.NREQ(NR), .W(WD), .HOLD(HD), .GAP(GP)) dut (
    .CLK(CLK), .RST(RST), .req(req), .data(data), .ack(ack), .busy(busy),
    .grant_id(grant_id), .lane_en(lane_en), .lane_d(lane_d)
  );

  function automatic int pick(input logic [NR-1:0] r);
    for (int k = 0; k < NR; k++) begin
      int j;
      j = (last + 1 + k) % NR;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic exp_lane(input logic [WD-1:0] w, input int c);
    if (c < HD) return 1'b1;
    if (c < (1 + WD) * HD) return w[(c - HD) / HD];
    if (PB == 1 && c < (2 + WD) * HD) return ^w;
    return 1'b0;
  endfunction

  // Runs one frame from the current IDLE state, applying an optional mid-frame event.
  task automatic run_frame(input int ev_c, input logic [NR-1:0] ev_set, input logic [NR-1:0] ev_clr,
                           input int ev_di, input logic [WD-1:0] ev_dv, output int waited);
    int eg;
    logic [WD-1:0] w;
    logic [NR-1:0] eack;
    eg = pick(req);
    w = '0;
    if (eg >= 0) w = data[eg*WD +: WD];
    waited = 0;
    do begin @(negedge CLK); waited++; end while (!busy && waited < 100);
    checks++;
    if (!busy || eg < 0) begin
      $display("FAIL frame_start busy=%0b expected 1 (model winner %0d)", busy, eg);
      return;
    end
    passed++;
    for (int c = 0; c < FL; c++) begin
      if (c > 0) @(negedge CLK);
      eack = (c == FL - 1) ? NR'(1 << eg) : '0;
      checks++;
      if (lane_d !== exp_lane(w, c))
        $display("FAIL lane_d req%0d cyc%0d got %b expected %b", eg, c, lane_d, exp_lane(w, c));
      else passed++;
      checks++;
      if (ack !== eack) $display("FAIL ack req%0d cyc%0d got %b expected %b", eg, c, ack, eack);
      else passed++;
      checks++;
      if (grant_id !== 3'(eg) || busy !== 1'b1 || lane_en !== 1'b1)
        $display("FAIL grant cyc%0d got id=%0d busy=%b en=%b expected id=%0d busy=1 en=1",
                 c, grant_id, busy, lane_en, eg);
      else passed++;
      if (c == ev_c) begin
        req = (req | ev_set) & ~ev_clr;
        if (ev_di >= 0) data[ev_di*WD +: WD] = ev_dv;
      end
    end
    req[eg] = 1'b0;
    last = eg;
  endtask

  task automatic apply_reset();
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    last = NR - 1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    checks++; if (ack !== '0) $display("FAIL rst_ack got %b expected 0", ack); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL rst_busy got %b expected 0", busy); else passed++;
    checks++; if (grant_id !== 3'd0) $display("FAIL rst_grant got %0d expected 0", grant_id); else passed++;
    checks++; if (lane_en !== 1'b1) $display("FAIL rst_lane_en got %b expected 1", lane_en); else passed++;
    checks++; if (lane_d !== 1'b0) $display("FAIL rst_lane_d got %b expected 0", lane_d); else passed++;
    RST = 1'b0;
    last = NR - 1;
  endtask

  task automatic test_single();
    int n;
    data[2*WD +: WD] = 8'hA5;
    req = 4'b0100;
    run_frame(-1, '0, '0, -1, '0, n);
    @(negedge CLK);
    checks++;
    if (busy !== 1'b0 || ack !== '0) $display("FAIL single_after got busy=%b ack=%b expected 0/0", busy, ack);
    else passed++;
  endtask

  task automatic test_round_robin();
    int n;
    apply_reset();
    for (int i = 0; i < NR; i++) data[i*WD +: WD] = WD'($urandom);
    req = '1;
    for (int f = 0; f < 5; f++) begin
      run_frame(-1, '0, '0, -1, '0, n);
      if (f > 0) begin
        checks++;
        if (n !== 2) $display("FAIL rr_idle_gap frame%0d got %0d cycles to START expected 2", f, n);
        else passed++;
      end
      data[last*WD +: WD] = WD'($urandom);
      req = (f == 4) ? '0 : '1;
    end
  endtask

  task automatic test_late_drop();
    int n;
    data[3*WD +: WD] = WD'($urandom);
    data[1*WD +: WD] = WD'($urandom);
    req = 4'b1000;
    run_frame(12, 4'b0010, 4'b1000, -1, '0, n);
    run_frame(-1, '0, '0, -1, '0, n);
    checks++;
    if (n !== 2) $display("FAIL late_req_wait got %0d cycles to START expected 2", n); else passed++;
  endtask

  task automatic test_data_stable();
    int n;
    @(negedge CLK);
    data[0 +: WD] = 8'h0F;
    req = 4'b0001;
    run_frame(10, '0, '0, 0, 8'hF0, n);
  endtask

  task automatic test_reset_mid();
    int n;
    @(negedge CLK);
    data[0 +: WD] = WD'($urandom);
    data[1*WD +: WD] = WD'($urandom);
    req = 4'b0010;
    n = 0;
    do begin @(negedge CLK); n++; end while (!busy && n < 100);
    checks++; if (!busy) $display("FAIL rstmid_start busy=%b expected 1", busy); else passed++;
    for (int c = 1; c <= 21; c++) @(negedge CLK);
    RST = 1'b1;
    req[0] = 1'b1;
    @(negedge CLK);
    checks++; if (lane_d !== 1'b0) $display("FAIL rstmid_lane got %b expected 0", lane_d); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy got %b expected 0", busy); else passed++;
    checks++; if (ack !== '0) $display("FAIL rstmid_ack got %b expected 0", ack); else passed++;
    RST = 1'b0;
    last = NR - 1;
    run_frame(-1, '0, '0, -1, '0, n);
    run_frame(-1, '0, '0, -1, '0, n);
  endtask

  task automatic test_random();
    int n;
    logic [NR-1:0] m;
    for (int it = 0; it < 8; it++) begin
      m = NR'($urandom_range(1, (1 << NR) - 1));
      for (int i = 0; i < NR; i++)
        if (m[i] && !req[i]) data[i*WD +: WD] = WD'($urandom);
      req = req | m;
      run_frame(-1, '0, '0, -1, '0, n);
    end
    for (int k = 0; k < NR && req != '0; k++) run_frame(-1, '0, '0, -1, '0, n);
  endtask

`ifdef SYNC_LANE_PARITY_EN
  task automatic test_parity();
    int n;
    @(negedge CLK);
    data[2*WD +: WD] = 8'h07;
    req = 4'b0100;
    run_frame(-1, '0, '0, -1, '0, n);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_late_drop();
    test_data_stable();
    test_reset_mid();
    test_random();
`ifdef SYNC_LANE_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
